muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter ITER, default 32, giving the iteration count (one bit per cycle).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled each rising edge.
REQ-005 The block SHALL have port op, input, 2 bits: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
REQ-006 The block SHALL have port input1, input, 32 bits: multiplicand, dividend, or MTHI/MTLO source.
REQ-007 The block SHALL have port input2, input, 32 bits: multiplier or divisor.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an iterative operation runs; the pipeline stalls EX on it.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse, HI/LO hold a new MULTU/DIVU result.
REQ-010 The block SHALL have port div_by_zero, output, 1 bit: valid with done; high when the DIVU divisor was 0.
REQ-011 The block SHALL have ports HI and LO, outputs, 32 bits each: the architectural HI/LO registers, read by the mfhi/mflo path into the ALU.

Function
REQ-012 The block SHALL implement states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start with op MULTU/DIVU SHALL capture input1, input2 and op, clear the iteration counter, and enter RUN at that edge.
REQ-014 In IDLE or DONE, start with op MTHI/MTLO SHALL write input1 to HI or LO at that edge; the state becomes/stays IDLE and done is not asserted.
REQ-015 In RUN, the block SHALL perform exactly one iteration per cycle; after the ITER-th iteration edge it SHALL enter DONE and HI/LO SHALL take the result at that same edge.
REQ-016 Latency: start sampled at edge k SHALL give busy=1 for the cycles following edges k..k+ITER-1, and done=1, busy=0 in the cycle following edge k+ITER.
REQ-017 DONE SHALL last one cycle, then go to IDLE, unless a new start is accepted (back-to-back, no bubble).
REQ-018 start SHALL be ignored while in RUN; captured operands SHALL NOT change mid-operation.
REQ-019 MULTU SHALL be unsigned shift-add: {HI,LO} = input1*input2, full 64-bit product, no overflow.
REQ-020 DIVU SHALL be unsigned restoring division using a 33-bit subtract: LO = quotient, HI = remainder.
REQ-021 DIVU with input2=0 SHALL still take ITER cycles and yield LO=32'hFFFFFFFF, HI=input1, div_by_zero=1 during done.
REQ-022 div_by_zero SHALL be 0 whenever done=0 and for MULTU.
REQ-023 HI and LO SHALL be unchanged during RUN and SHALL hold their value indefinitely in IDLE.
REQ-024 The iteration counter SHALL be $clog2(ITER)+1 bits wide; it does not wrap in RUN because exit occurs at count ITER-1.

Reset
REQ-025 With rst_n=0 at an edge, the state SHALL go to IDLE and HI, LO, busy, done and div_by_zero SHALL all be 0, regardless of state (including mid-RUN; the partial result is discarded).
REQ-026 When start and rst_n=0 occur at the same edge, reset SHALL win and the start SHALL be dropped.

Structure
REQ-027 A package muldiv_pkg SHALL hold the op encodings (OP_MULTU, OP_DIVU, OP_MTHI, OP_MTLO), the state encoding and the ITER default.
REQ-028 One combinational sub-module, muldiv_addsub (33-bit add/subtract with carry/borrow out), SHALL be shared by the multiply and divide iteration.

Verification
REQ-029 MULTU with 7 and 6: busy for 32 cycles, then done with HI=0, LO=42.
REQ-030 MULTU with FFFFFFFF and FFFFFFFF: done with HI=FFFFFFFE, LO=00000001.
REQ-031 DIVU with 100 and 7: LO=14, HI=2, div_by_zero=0; then DIVU with 5 and 0: LO=FFFFFFFF, HI=5, div_by_zero=1.
REQ-032 A start (MULTU 3,3) asserted at cycle 10 of a running DIVU 100/7 SHALL be ignored: the DIVU result is unchanged and there is exactly one done pulse.
REQ-033 rst_n=0 at cycle 15 of a MULTU SHALL give HI=LO=0, busy=0 on the next cycle, and no done pulse.
REQ-034 MTHI 0xDEADBEEF then MTLO 0x12345678 on consecutive cycles SHALL give HI=DEADBEEF, LO=12345678, and done never asserted; a start in the DONE cycle SHALL run back-to-back.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned ITER_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_DIVU  = 2'b01,
        OP_MTHI  = 2'b10,
        OP_MTLO  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_addsub.sv
// 33-bit adder/subtractor shared by the multiply and divide iterations.
// o_cout is the carry out when adding and the borrow out when subtracting.
module muldiv_addsub (
    input  logic        i_sub,
    input  logic [32:0] i_a,
    input  logic [32:0] i_b,
    output logic [32:0] o_y,
    output logic        o_cout
);

    logic [32:0] w_b;
    logic        w_carry;

    always_comb begin
        w_b = i_sub ? ~i_b : i_b;
        {w_carry, o_y} = {1'b0, i_a} + {1'b0, w_b} + {33'd0, i_sub};
        o_cout = i_sub ? ~w_carry : w_carry;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit owning the architectural HI/LO registers.
// One bit per cycle; MTHI/MTLO write HI/LO directly when the unit is not running.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned ITER = ITER_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned CW = $clog2(ITER) + 1;

    state_e        r_state;
    state_e        w_state_nx;
    op_e           r_op;
    logic [31:0]   r_acc;
    logic [31:0]   r_q;
    logic [31:0]   r_d;
    logic [CW-1:0] r_cnt;
    logic          r_dbz;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    logic          w_last;
    logic          w_mul;
    logic [32:0]   w_as_a;
    logic [32:0]   w_as_b;
    logic [32:0]   w_sum;
    logic          w_cout;
    logic [31:0]   w_acc_nx;
    logic [31:0]   w_q_nx;

    assign w_last = (r_cnt == CW'(ITER - 1));
    assign w_mul  = (r_op == OP_MULTU);

    // Multiply: {acc,q} shifts right, adding the multiplicand when q[0] is set.
    // Divide: {rem,q} shifts left, subtracting the divisor from the 33-bit window.
    assign w_as_a = w_mul ? {1'b0, r_acc} : {r_acc, r_q[31]};
    assign w_as_b = {1'b0, r_d};

    muldiv_addsub u_addsub (
        .i_sub  (~w_mul),
        .i_a    (w_as_a),
        .i_b    (w_as_b),
        .o_y    (w_sum),
        .o_cout (w_cout)
    );

    always_comb begin
        w_acc_nx = r_acc;
        w_q_nx   = r_q;
        if (w_mul) begin
            if (r_q[0]) begin
                w_acc_nx = w_sum[32:1];
                w_q_nx   = {w_sum[0], r_q[31:1]};
            end else begin
                w_acc_nx = {1'b0, r_acc[31:1]};
                w_q_nx   = {r_acc[0], r_q[31:1]};
            end
        end else begin
            if (!w_cout) begin
                w_acc_nx = w_sum[31:0];
                w_q_nx   = {r_q[30:0], 1'b1};
            end else begin
                w_acc_nx = w_as_a[31:0];
                w_q_nx   = {r_q[30:0], 1'b0};
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE, DONE: begin
                w_state_nx = IDLE;
                if (start && (op == OP_MULTU || op == OP_DIVU)) begin
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nx = DONE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op    <= OP_MULTU;
            r_acc   <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_dbz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == RUN) begin
                r_acc <= w_acc_nx;
                r_q   <= w_q_nx;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_hi <= w_acc_nx;
                    r_lo <= w_q_nx;
                end
            end else if (start) begin
                case (op_e'(op))
                    OP_MULTU, OP_DIVU: begin
                        r_op  <= op_e'(op);
                        r_acc <= '0;
                        r_q   <= input1;
                        r_d   <= input2;
                        r_cnt <= '0;
                        r_dbz <= (op == OP_DIVU) && (input2 == '0);
                    end
                    OP_MTHI: r_hi <= input1;
                    OP_MTLO: r_lo <= input1;
                    default: ;
                endcase
            end
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign div_by_zero = done && r_dbz;
    assign HI          = r_hi;
    assign LO          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops against
// an arithmetic reference model, and hand-written multi-cycle corner sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned ITER = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] input1 = '0;
    logic [31:0] input2 = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.ITER(ITER)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .input1      (input1),
        .input2      (input2),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .HI          (HI),
        .LO          (LO)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {div_by_zero, HI, LO} from plain arithmetic.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (o == OP_MULTU) begin
            p = {32'd0, a} * {32'd0, b};
            return {1'b0, p};
        end
        if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
        return {1'b0, a % b, a / b};
    endfunction

    // Issue one MULTU/DIVU, wait (bounded) for done, check latency and HI/LO stability.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [64:0] res);
        logic [31:0] hi0, lo0;
        logic        stable;
        int          nbusy, cyc;
        @(negedge clk);
        start = 1'b1; op = o; input1 = a; input2 = b;
        @(negedge clk);
        start = 1'b0;
        hi0 = HI; lo0 = LO; stable = 1'b1; nbusy = 0; cyc = 0;
        while (!done && cyc < 4 * ITER) begin
            if (busy) nbusy++;
            if (HI !== hi0 || LO !== lo0) stable = 1'b0;
            cyc++;
            @(negedge clk);
        end
        res = {div_by_zero, HI, LO};
        chk("done_seen", 65'(done), 65'd1);
        chk("busy_cycles", 65'(nbusy), 65'(ITER));
        chk("busy_at_done", 65'(busy), 65'd0);
        chk("hilo_stable_in_run", 65'(stable), 65'd1);
        @(negedge clk);
        chk("done_one_cycle", 65'(done), 65'd0);
        chk("dbz_low_after_done", 65'(div_by_zero), 65'd0);
        chk("hilo_held_idle", {1'b0, HI, LO}, {1'b0, res[63:0]});
    endtask

    vec_t        tbl[8];
    logic [64:0] res;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          ndone, done_at, cyc;

    initial begin
        tbl[0] = '{OP_MULTU, 32'd7,          32'd6,          32'd0,          32'd42,         1'b0};
        tbl[1] = '{OP_MULTU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   32'h00000001,   1'b0};
        tbl[2] = '{OP_DIVU,  32'd100,        32'd7,          32'd2,          32'd14,         1'b0};
        tbl[3] = '{OP_DIVU,  32'd5,          32'd0,          32'd5,          32'hFFFFFFFF,   1'b1};
        tbl[4] = '{OP_MULTU, 32'h00010000,   32'h00010000,   32'd1,          32'd0,          1'b0};
        tbl[5] = '{OP_DIVU,  32'hFFFFFFFF,   32'd1,          32'd0,          32'hFFFFFFFF,   1'b0};
        tbl[6] = '{OP_DIVU,  32'd3,          32'd10,         32'd3,          32'd0,          1'b0};
        tbl[7] = '{OP_DIVU,  32'h80000000,   32'h80000000,   32'd0,          32'd1,          1'b0};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy, done, div_by_zero, 30'd0, HI[31:0]}, 65'd0);
        chk("reset_lo", 65'(LO), 65'd0);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, res);
            chk($sformatf("vec%0d_result", i), res, {tbl[i].dbz, tbl[i].hi, tbl[i].lo});
        end

        // Random ops against the reference model
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 1));
            ra = $urandom();
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 255));
                default: rb = $urandom();
            endcase
            run_op(ro, ra, rb, res);
            chk($sformatf("rand%0d_result", i), res, model(ro, ra, rb));
        end

        // Start during RUN is ignored
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; input1 = 32'd100; input2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; done_at = 0;
        for (int c = 1; c <= ITER + 12; c++) begin
            if (c == 10) begin
                start = 1'b1; op = OP_MULTU; input1 = 32'd3; input2 = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (done_at == 0) begin
                    done_at = c;
                    res = {div_by_zero, HI, LO};
                end
            end
            @(negedge clk);
        end
        chk("ignore_start_pulses", 65'(ndone), 65'd1);
        chk("ignore_start_latency", 65'(done_at), 65'(ITER + 1));
        chk("ignore_start_result", res, {1'b0, 32'd2, 32'd14});

        // Reset mid-RUN discards the operation
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; input1 = 32'd5; input2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 15; c++) @(negedge clk);
        chk("midrun_busy_before_reset", 65'(busy), 65'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrun_reset_state", {busy, done, div_by_zero, HI, LO}, 65'd0);
        ndone = 0;
        for (int c = 0; c < 2 * ITER; c++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        chk("midrun_reset_no_done", 65'(ndone), 65'd0);

        // Reset and start at the same edge: reset wins
        rst_n = 1'b0; start = 1'b1; op = OP_MTHI; input1 = 32'hA5A5A5A5;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        chk("reset_beats_start", {busy, done, div_by_zero, HI, LO}, 65'd0);

        // MTHI then MTLO on consecutive cycles
        ndone = 0;
        start = 1'b1; op = OP_MTHI; input1 = 32'hDEADBEEF;
        @(negedge clk);
        if (done || busy) ndone++;
        op = OP_MTLO; input1 = 32'h12345678;
        @(negedge clk);
        if (done || busy) ndone++;
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("mthi_mtlo_hilo", {1'b0, HI, LO}, {1'b0, 32'hDEADBEEF, 32'h12345678});
        chk("mthi_mtlo_no_done", 65'(ndone), 65'd0);

        // Back-to-back: new start accepted in the DONE cycle
        start = 1'b1; op = OP_MULTU; input1 = 32'd7; input2 = 32'd6;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 4 * ITER) begin
            cyc++;
            @(negedge clk);
        end
        chk("b2b_first_done", {done, HI, LO}, {1'b1, 32'd0, 32'd42});
        start = 1'b1; op = OP_DIVU; input1 = 32'd100; input2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_bubble", {63'd0, busy, done}, 65'd2);
        ndone = 1;
        cyc = 0;
        while (!done && cyc < 4 * ITER) begin
            if (busy) ndone++;
            cyc++;
            @(negedge clk);
        end
        chk("b2b_second_busy", 65'(ndone - 1), 65'(ITER));
        chk("b2b_second_result", {div_by_zero, HI, LO}, {1'b0, 32'd2, 32'd14});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
